// File: rtl/spi_input_front_pkg.sv
// Shared idle levels, default debounce depth and glitch counter type for the SPI input front end.
package spi_input_front_pkg;

    localparam logic SPI_CS_IDLE      = 1'b1;
    localparam logic SPI_SCLK_IDLE    = 1'b0;
    localparam logic SPI_MOSI_IDLE    = 1'b0;
    localparam int   SPI_WAIT_DEFAULT = 3;

    typedef logic [7:0] glitch_cnt_t;

    localparam glitch_cnt_t GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/spi_input_front_input_conditioner.sv
// One SPI pin: 2-flop synchronizer followed by a WAIT-cycle debounce filter with registered
// edge strobes; reject_p flags an aborted pending change (s2 reverts while counting).
module input_conditioner
    import spi_input_front_pkg::*;
#(
    parameter int   WAIT  = SPI_WAIT_DEFAULT,
    parameter int   CNT_W = 2,
    parameter logic IDLE  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    input  logic strobe_en,
    output logic conditioned,
    output logic posedge_p,
    output logic negedge_p,
    output logic reject_p
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             cond_q, cond_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= IDLE;
            s2_q   <= IDLE;
            cond_q <= IDLE;
            cnt_q  <= '0;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cond_q <= cond_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    // Strobes are gated at the register so they leave the block aligned with cond.
    always_comb begin
        s1_d   = noisy;
        s2_d   = s1_q;
        cond_d = cond_q;
        cnt_d  = cnt_q;
        pos_d  = 1'b0;
        neg_d  = 1'b0;
        if (s2_q == cond_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(WAIT - 1)) begin
            cond_d = s2_q;
            cnt_d  = '0;
            pos_d  = s2_q & strobe_en;
            neg_d  = ~s2_q & strobe_en;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign conditioned = cond_q;
    assign posedge_p   = pos_q;
    assign negedge_p   = neg_q;
    assign reject_p    = (s2_q == cond_q) && (cnt_q != '0);

endmodule

// File: rtl/spi_input_front.sv
// SPI pin front end: conditions sclk/cs/mosi, gates sclk strobes with cs, emits frame strobes.
// Define SPI_GLITCH_CNT_EN to add the saturating sclk glitch counter output glitch_cnt.
module spi_input_front
    import spi_input_front_pkg::*;
#(
    parameter int WAIT  = SPI_WAIT_DEFAULT,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic sclk_cond,
    output logic cs_cond,
    output logic mosi_cond,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic frame_start,
    output logic frame_end
`ifdef SPI_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    logic sclk_reject;
    logic cs_reject;
    logic mosi_pos, mosi_neg, mosi_reject;
    logic unused_bits;

    // cs_cond is the pre-update level on the edge where sclk acceptance happens.
    input_conditioner #(.WAIT(WAIT), .CNT_W(CNT_W), .IDLE(SPI_SCLK_IDLE)) u_sclk (
        .clk         (clk),
        .rst_n       (rst_n),
        .noisy       (sclk_pin),
        .strobe_en   (~cs_cond),
        .conditioned (sclk_cond),
        .posedge_p   (sclk_rise),
        .negedge_p   (sclk_fall),
        .reject_p    (sclk_reject)
    );

    input_conditioner #(.WAIT(WAIT), .CNT_W(CNT_W), .IDLE(SPI_CS_IDLE)) u_cs (
        .clk         (clk),
        .rst_n       (rst_n),
        .noisy       (cs_pin),
        .strobe_en   (1'b1),
        .conditioned (cs_cond),
        .posedge_p   (frame_end),
        .negedge_p   (frame_start),
        .reject_p    (cs_reject)
    );

    input_conditioner #(.WAIT(WAIT), .CNT_W(CNT_W), .IDLE(SPI_MOSI_IDLE)) u_mosi (
        .clk         (clk),
        .rst_n       (rst_n),
        .noisy       (mosi_pin),
        .strobe_en   (1'b1),
        .conditioned (mosi_cond),
        .posedge_p   (mosi_pos),
        .negedge_p   (mosi_neg),
        .reject_p    (mosi_reject)
    );

    assign unused_bits = ^{sclk_reject, cs_reject, mosi_pos, mosi_neg, mosi_reject};

`ifdef SPI_GLITCH_CNT_EN
    glitch_cnt_t glitch_q, glitch_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        glitch_d = glitch_q;
        if (frame_start) begin
            glitch_d = '0;
        end else if (sclk_reject && (glitch_q != GLITCH_CNT_MAX)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_spi_input_front.sv
// Scoreboard bench for spi_input_front: a window-based reference model predicts every cycle's outputs.
module tb_spi_input_front;

    localparam int WAIT = 3;
`ifdef SPI_GLITCH_CNT_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_pin = 1'b0, cs_pin = 1'b1, mosi_pin = 1'b0;
    logic sclk_cond, cs_cond, mosi_cond, sclk_rise, sclk_fall, frame_start, frame_end;
    logic [7:0] glitch_act;

    always #5 clk = ~clk;

    spi_input_front #(.WAIT(WAIT), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_pin    (sclk_pin),
        .cs_pin      (cs_pin),
        .mosi_pin    (mosi_pin),
        .sclk_cond   (sclk_cond),
        .cs_cond     (cs_cond),
        .mosi_cond   (mosi_cond),
        .sclk_rise   (sclk_rise),
        .sclk_fall   (sclk_fall),
        .frame_start (frame_start),
        .frame_end   (frame_end)
`ifdef SPI_GLITCH_CNT_EN
        ,
        .glitch_cnt  (glitch_act)
`endif
    );
`ifndef SPI_GLITCH_CNT_EN
    assign glitch_act = 8'h00;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Pin p's level is accepted when the WAIT most recent synchronized samples all differ from it.
    // hist[p][i] is the pin value seen i edges ago (index 0 = this edge); sync delay puts s2 at index 2.
    bit        hist [3][$];
    bit        mcond [3];
    bit        idle_lvl [3] = '{1'b0, 1'b1, 1'b0};
    int        mglitch;
    bit        prev_fs;
    logic [14:0] exp_q [$];

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            hist[p].delete();
            for (int i = 0; i < WAIT + 4; i++) hist[p].push_back(idle_lvl[p]);
            mcond[p] = idle_lvl[p];
        end
        mglitch = 0;
        prev_fs = 1'b0;
    endtask

    always @(posedge clk) begin
        bit acc [3];
        bit rej;
        bit rise, fall, fs, fe;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b0, 4'b0000});
        end else begin
            hist[0].push_front(sclk_pin); void'(hist[0].pop_back());
            hist[1].push_front(cs_pin);   void'(hist[1].pop_back());
            hist[2].push_front(mosi_pin); void'(hist[2].pop_back());
            for (int p = 0; p < 3; p++) begin
                acc[p] = 1'b1;
                for (int i = 2; i <= WAIT + 1; i++)
                    if (hist[p][i] == mcond[p]) acc[p] = 1'b0;
            end
            rej  = (hist[0][2] == mcond[0]) && (hist[0][3] != mcond[0]);
            rise = acc[0] && !mcond[0] && !mcond[1];
            fall = acc[0] &&  mcond[0] && !mcond[1];
            fs   = acc[1] &&  mcond[1];
            fe   = acc[1] && !mcond[1];
            if (prev_fs) mglitch = 0;
            else if (rej && mglitch < 255) mglitch++;
            for (int p = 0; p < 3; p++) if (acc[p]) mcond[p] = !mcond[p];
            prev_fs = fs;
            exp_q.push_back({8'(mglitch), mcond[0], mcond[1], mcond[2], rise, fall, fs, fe});
        end
    end

    // ---------------- monitor ----------------
    int rise_cnt = 0, fall_cnt = 0, fs_cnt = 0, fe_cnt = 0;
    logic [7:0] mosi_cap = 8'h00;

    always @(negedge clk) begin
        logic [14:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!GLITCH_EN) e[14:7] = 8'h00;
            a = {glitch_act, sclk_cond, cs_cond, mosi_cond, sclk_rise, sclk_fall, frame_start, frame_end};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t actual={g=%h sc=%b cs=%b mo=%b r=%b f=%b fs=%b fe=%b} required={g=%h sc=%b cs=%b mo=%b r=%b f=%b fs=%b fe=%b}",
                         $time, a[14:7], a[6], a[5], a[4], a[3], a[2], a[1], a[0],
                         e[14:7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
        if (sclk_rise) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[6:0], mosi_cond};
        end
        if (sclk_fall)   fall_cnt++;
        if (frame_start) fs_cnt++;
        if (frame_end)   fe_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        int r0, f0, s0, e0;
        int hold [3];
        bit v [3];
        logic [7:0] pattern;

        step(3);
        rst_n = 1'b1;
        step(6);

        // cs assert: cond falls 4 edges after the first sampling edge
        s0 = fs_cnt;
        cs_pin = 1'b0;
        step(4);
        check("cs_cond_before_k4", 16'(cs_cond), 16'd1);
        step(1);
        check("cs_cond_at_k4", 16'(cs_cond), 16'd0);
        check("frame_start_at_k4", 16'(frame_start), 16'd1);
        step(1);
        check("frame_start_width", 16'(frame_start), 16'd0);
        step(4);
        check("frame_start_count", 16'(fs_cnt - s0), 16'd1);

        // 2-cycle sclk glitch inside a frame
        r0 = rise_cnt;
        sclk_pin = 1'b1;
        step(2);
        sclk_pin = 1'b0;
        step(8);
        check("glitch_no_rise", 16'(rise_cnt - r0), 16'd0);
        check("glitch_sclk_cond", 16'(sclk_cond), 16'd0);
`ifdef SPI_GLITCH_CNT_EN
        check("glitch_cnt_one", 16'(glitch_act), 16'd1);
`endif

        // 8-bit transfer, mosi set with the falling phase
        pattern = 8'hA5;
        r0 = rise_cnt;
        f0 = fall_cnt;
        for (int i = 7; i >= 0; i--) begin
            mosi_pin = pattern[i];
            sclk_pin = 1'b0;
            step(5);
            sclk_pin = 1'b1;
            step(5);
        end
        sclk_pin = 1'b0;
        step(8);
        check("xfer_rise_count", 16'(rise_cnt - r0), 16'd8);
        check("xfer_fall_count", 16'(fall_cnt - f0), 16'd8);
        check("xfer_mosi_byte", 16'(mosi_cap), 16'h00A5);

        // reset in the middle of a transfer
        sclk_pin = 1'b1;
        step(5);
        sclk_pin = 1'b0;
        step(2);
        rst_n = 1'b0;
        #1;
        check("async_reset_idle", 16'({sclk_cond, cs_cond, sclk_rise, sclk_fall, frame_start, frame_end}), 16'b010000);
        step(3);
        rst_n = 1'b1;
        step(8);

        // sclk toggles while deselected
        cs_pin = 1'b1;
        step(8);
        r0 = rise_cnt;
        f0 = fall_cnt;
        for (int i = 0; i < 4; i++) begin
            sclk_pin = 1'b1;
            step(5);
            sclk_pin = 1'b0;
            step(5);
        end
        check("idle_rise_count", 16'(rise_cnt - r0), 16'd0);
        check("idle_fall_count", 16'(fall_cnt - f0), 16'd0);

        // simultaneous cs assert + sclk rise: suppressed
        r0 = rise_cnt;
        s0 = fs_cnt;
        cs_pin = 1'b0;
        sclk_pin = 1'b1;
        step(8);
        check("cs_assert_rise_suppressed", 16'(rise_cnt - r0), 16'd0);
        check("cs_assert_frame_start", 16'(fs_cnt - s0), 16'd1);
        f0 = fall_cnt;
        sclk_pin = 1'b0;
        step(8);
        check("in_frame_fall", 16'(fall_cnt - f0), 16'd1);
        // simultaneous cs deassert + sclk rise: still fires
        r0 = rise_cnt;
        e0 = fe_cnt;
        cs_pin = 1'b1;
        sclk_pin = 1'b1;
        step(8);
        check("cs_deassert_rise_fires", 16'(rise_cnt - r0), 16'd1);
        check("cs_deassert_frame_end", 16'(fe_cnt - e0), 16'd1);
        sclk_pin = 1'b0;
        step(8);

        // 300 glitches inside one frame
        cs_pin = 1'b0;
        step(8);
        r0 = rise_cnt;
        for (int i = 0; i < 300; i++) begin
            sclk_pin = 1'b1;
            step(2);
            sclk_pin = 1'b0;
            step(2);
        end
        step(4);
        check("glitch_train_no_rise", 16'(rise_cnt - r0), 16'd0);
`ifdef SPI_GLITCH_CNT_EN
        check("glitch_cnt_saturated", 16'(glitch_act), 16'd255);
`endif

        // randomized pin activity
        for (int p = 0; p < 3; p++) begin
            hold[p] = 0;
            v[p] = idle_lvl[p];
        end
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (hold[p] == 0) begin
                    v[p] = 1'($urandom_range(0, 1));
                    hold[p] = (p == 1) ? $urandom_range(6, 40) : $urandom_range(1, 8);
                end
                hold[p]--;
            end
            sclk_pin = v[0];
            cs_pin   = v[1];
            mosi_pin = v[2];
            step(1);
        end
        step(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
